program_counter_unit: RTL and testbench

16-bit program counter for the CPU core, sitting directly downstream of the branch unit. Consumes that unit's `branch`, `lower_byte`, `normal` and `pc_increment` strobes plus the internal data bus, and drives the fetch address. Supports increment, absolute loads via a low-byte holding latch (reset vector, JMP), and signed 8-bit relative branches. Relative branches that cross a page take an extra fix-up cycle.

---
 rtl/program_counter_unit.sv | 104 ++++++++++
 tb/tb_program_counter_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/program_counter_unit.sv
// 16-bit program counter: increment, absolute load via low-byte latch, signed 8-bit relative branch.
// Define PAGE_CROSS_PENALTY_EN to correct the high byte in a separate stall cycle on page-crossing branches.
module program_counter_unit (
  input  logic        clk_1,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic        branch,
  input  logic        lower_byte,
  input  logic        normal,
  input  logic        pc_increment,
  input  logic        rel_mode,
  output logic [15:0] pc,
  output logic        stall
);

  logic [15:0] r_pc;
  logic [7:0]  r_lo_latch;
  logic        w_rel;

  // During the reset-vector sequence every branch is an absolute load.
  assign w_rel = rel_mode & normal;

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      r_lo_latch <= 8'h00;
    end else if (lower_byte) begin
      r_lo_latch <= data_in;
    end
  end

`ifdef PAGE_CROSS_PENALTY_EN
  typedef enum logic {ST_IDLE, ST_FIX} state_t;

  state_t     r_state;
  logic       r_fix_dir;
  logic       r_stall;
  logic [8:0] w_sum9;
  logic       w_cross_inc;
  logic       w_cross_dec;

  assign w_sum9      = {1'b0, r_pc[7:0]} + {1'b0, data_in};
  assign w_cross_inc = ~data_in[7] &  w_sum9[8];
  assign w_cross_dec =  data_in[7] & ~w_sum9[8];

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      r_pc      <= 16'hFFFC;
      r_state   <= ST_IDLE;
      r_fix_dir <= 1'b0;
      r_stall   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (branch) begin
            if (w_rel) begin
              r_pc[7:0] <= w_sum9[7:0];
              if (w_cross_inc || w_cross_dec) begin
                r_state   <= ST_FIX;
                r_stall   <= 1'b1;
                r_fix_dir <= w_cross_inc;
              end
            end else begin
              r_pc <= {data_in, r_lo_latch};
            end
          end else if (pc_increment) begin
            r_pc <= r_pc + 16'd1;
          end
        end
        ST_FIX: begin
          // Strobes are held upstream during the fix-up, so they are ignored here.
          r_pc[15:8] <= r_fix_dir ? (r_pc[15:8] + 8'd1) : (r_pc[15:8] - 8'd1);
          r_state    <= ST_IDLE;
          r_stall    <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  assign stall = r_stall;
`else
  logic [15:0] w_rel_target;

  assign w_rel_target = r_pc + {{8{data_in[7]}}, data_in};

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      r_pc <= 16'hFFFC;
    end else if (branch) begin
      r_pc <= w_rel ? w_rel_target : {data_in, r_lo_latch};
    end else if (pc_increment) begin
      r_pc <= r_pc + 16'd1;
    end
  end

  assign stall = 1'b0;
`endif

  assign pc = r_pc;

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed bench for program_counter_unit; follows PAGE_CROSS_PENALTY_EN for expected page-cross timing.
module tb_program_counter_unit;

  logic        clk_1 = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic        branch = 1'b0;
  logic        lower_byte = 1'b0;
  logic        normal = 1'b1;
  logic        pc_increment = 1'b0;
  logic        rel_mode = 1'b0;
  logic [15:0] pc;
  logic        stall;

  int total = 0;
  int bad = 0;

  program_counter_unit dut (
    .clk_1       (clk_1),
    .rst         (rst),
    .data_in     (data_in),
    .branch      (branch),
    .lower_byte  (lower_byte),
    .normal      (normal),
    .pc_increment(pc_increment),
    .rel_mode    (rel_mode),
    .pc          (pc),
    .stall       (stall)
  );

  always #5 clk_1 = ~clk_1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Apply one set of strobes for a single rising edge, then return them to idle.
  task automatic cyc(input logic br, input logic lb, input logic nm, input logic inc,
                     input logic rel, input logic [7:0] d);
    branch = br; lower_byte = lb; normal = nm; pc_increment = inc; rel_mode = rel; data_in = d;
    @(posedge clk_1);
    #1;
    branch = 1'b0; lower_byte = 1'b0; normal = 1'b1; pc_increment = 1'b0; rel_mode = 1'b0;
  endtask

  task automatic load_abs(input logic [15:0] a);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, a[7:0]);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, a[15:8]);
  endtask

  initial begin
    #12;
    check("reset_pc", pc, 16'hFFFC);
    check("reset_stall", stall, 1'b0);
    rst = 1'b0;
    @(posedge clk_1);
    #1;
    check("idle_hold", pc, 16'hFFFC);

    // Reset-vector sequence
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h34);
    check("rv_edgeA", pc, 16'hFFFD);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12);
    check("rv_edgeB", pc, 16'h1234);

    // Asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    check("async_rst_pc", pc, 16'hFFFC);
    check("async_rst_stall", stall, 1'b0);
    rst = 1'b0;

    // Increment up to and across the wrap
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    check("inc_to_ffff", pc, 16'hFFFF);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    check("inc_wrap", pc, 16'h0000);

    // Branch beats increment; branch uses the latch value from before this edge
    load_abs(16'hFFFF);
    check("abs_ffff", pc, 16'hFFFF);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    check("latch_only_hold", pc, 16'hFFFF);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h80);
    check("br_beats_inc", pc, 16'h8000);

    // In-page relative, forward and backward
    load_abs(16'h1210);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h05);
    check("rel_inpage_fwd", pc, 16'h1215);
    check("rel_inpage_stall", stall, 1'b0);
    load_abs(16'h1220);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hF0);
    check("rel_inpage_bwd", pc, 16'h1210);

    // Forward page cross; increment and latch load held during the fix-up edge
    load_abs(16'h12F0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h20);
`ifdef PAGE_CROSS_PENALTY_EN
    check("xfwd_edge1_pc", pc, 16'h1210);
    check("xfwd_edge1_stall", stall, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hAB);
    check("xfwd_edge2_pc", pc, 16'h1310);
    check("xfwd_edge2_stall", stall, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55);
    check("latch_in_fix", pc, 16'h55AB);
`else
    check("xfwd_pc", pc, 16'h1310);
    check("xfwd_stall", stall, 1'b0);
`endif

    // Backward page cross
    load_abs(16'h1205);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hF0);
`ifdef PAGE_CROSS_PENALTY_EN
    check("xbwd_edge1_pc", pc, 16'h12F5);
    check("xbwd_edge1_stall", stall, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("xbwd_edge2_pc", pc, 16'h11F5);
    check("xbwd_edge2_stall", stall, 1'b0);
`else
    check("xbwd_pc", pc, 16'h11F5);
`endif

    // Reset while the fix-up is pending
    load_abs(16'h12F0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h20);
`ifdef PAGE_CROSS_PENALTY_EN
    check("fixrst_pre_stall", stall, 1'b1);
`endif
    #1 rst = 1'b1;
    #1;
    check("fixrst_pc", pc, 16'hFFFC);
    check("fixrst_stall", stall, 1'b0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    check("fixrst_inc", pc, 16'hFFFD);
    check("fixrst_inc_stall", stall, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
